alu_control_sequencer: RTL and testbench
========================================

# alu_control_sequencer

Hardwired control unit that sequences the Phase 1 datapath through instruction fetch and execution of register-format ALU instructions. It takes the place of the hand-written per-state control `case` logic used in the bench. It drives every datapath control strobe: `Rin`/`Rout` one-hots, PC/MAR/MDR/IR/Y/Z/HI/LO enables, `IncPC`, `Read` and `ALUop`. It decodes the IR value fed back from the datapath and handshakes fetches with memory.

## Interface
- `FETCH_TIMEOUT`, default 15: maximum cycles spent in T1 waiting for `mem_ready` before aborting.
- `clock` in 1: single system clock; all state changes on its rising edge.
- `clear` in 1: synchronous, active-high reset.
- `start` in 1: request to run one instruction; sampled only in IDLE.
- `ir` in 32: IR register output. Fields: [31:27] opcode, [26:23] Ra, [22:19] Rb, [18:15] Rc.
- `mem_ready` in 1: memory data valid on `Mdatain` this cycle.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid only with `done`. High means illegal opcode or fetch timeout.
- `Rin` and `Rout` out 16 each: register write and drive enables; one-hot or zero.
- `PCin`, `PCout`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zlowin`, `Zhighin`, `Zlowout`, `Zhighout`, `LOin`, `HIin`, `IncPC`, `Read` out 1 each: datapath strobes.
- `ALUop` out 4: ALU function select.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, DONE. All outputs are a Moore decode of state plus the decoded `ir`.
- IDLE: all strobes 0. On `start`=1 go to T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`. Go to T1.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin` held every cycle.
  - `mem_ready`=1: go to T2.
  - `mem_ready`=0 and wait counter = `FETCH_TIMEOUT`-1: go to DONE with err.
  - Otherwise stay in T1 and increment the counter. The counter clears on T1 entry.
- T2: `MDRout`, `IRin`. Go to T3.
- Opcodes, all else illegal: ADD 00011, SUB 00100, AND 00101, OR 00110, ROR 00111, ROL 01000, SHR 01001, SHRA 01010, SHL 01011, MUL 01111, DIV 10000, NEG 10001, NOT 10010.
- `ALUop` encodings: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 8, ROL 9, MUL 10, DIV 11, NEG 12, NOT 13.
- Binary instructions (all legal except NEG/NOT):
  - T3: `Rout[Rb]`, `Yin`.
  - T4: `Rout[Rc]`, `ALUop`, `Zlowin`; MUL/DIV also assert `Zhighin`.
  - T5: `Zlowout`. Non-MUL/DIV assert `Rin[Ra]` and go to DONE. MUL/DIV assert `LOin` and go to T6.
  - T6: `Zhighout`, `HIin`. Go to DONE.
- Unary instructions (NEG/NOT): T3 asserts `Rout[Rb]`, `ALUop`, `Zlowin`, then goes to T5. T5 asserts `Zlowout`, `Rin[Ra]`, then goes to DONE.
- Illegal opcode in T3: no strobes; go to DONE with err=1.
- DONE: `done`=1, all strobes 0, `err` as recorded. Go to IDLE.
- `ALUop` is 0 in every state where it is not explicitly driven.
- `start` outside IDLE is ignored. No queuing.

## Timing
- Reset: `clear`=1 at an edge forces IDLE, clears the wait counter and the err flag. This holds mid-instruction; an interrupted register write does not occur in the following cycle.
- All outputs reset to 0.
- Latency from the `start`-sampling edge to the `done` cycle, with `mem_ready` high in the first T1 cycle:
  - binary: 7 cycles
  - MUL/DIV: 8 cycles
  - NEG/NOT: 6 cycles
  - illegal: 5 cycles
- Each T1 wait cycle adds 1 cycle.
- `ir` is read from T3 to completion and must be stable from the T2 edge onward; IRin only pulses in T2.
- Timeout: with `mem_ready` stuck at 0, DONE follows exactly `FETCH_TIMEOUT` T1 cycles. `mem_ready` rising in the final allowed cycle wins and proceeds to T2.
- When Ra equals Rb or Rc, no special handling is needed: `Rin` and `Rout` are never asserted in the same state.

## Structure
- Shared package `cpu_ctrl_pkg` holds:
  - opcode constants
  - `ALUop` constants, shared with the ALU
  - state enum
  - IR field bit positions
- Sub-module `instr_decode` is combinational. It maps opcode to `ALUop` and class (binary, unary, hilo, illegal) and converts 4-bit register fields to 16-bit one-hots.
- Top level holds the FSM, the wait counter and the err flag.

## Test plan
- ROL with `ir`=0x43820000 (R7 ← R0 rol R4), R0=0x09, R4=0x02, `mem_ready` high in T1 → T3 asserts `Rout`=0x0001; T4 asserts `Rout`=0x0010 with `ALUop`=9; T5 asserts `Rin`=0x0080; R7=0x24; `done` in cycle 7; `err`=0.
- MUL R3×R4, R3=6, R4=7 → T5 asserts `LOin`, T6 asserts `HIin`, `Rin` stays 0; LO=42, HI=0; `done` in cycle 8.
- NOT with Ra=2, Rb=5, R5=0x0000FFFF → state order T3→T5; R2=0xFFFF0000; `done` in cycle 6.
- `mem_ready` low for 3 T1 cycles, then high → `Read`/`MDRin` held 4 cycles, single IR load, `done` in cycle 10. Held low for 15 cycles → `done`+`err` with no IRin.
- Opcode 11111 → `done`+`err` in cycle 5; `Rin`, `Yin` and `Zlowin` never asserted after T0.
- `clear` asserted during T4 → IDLE next edge, all outputs 0, no `Rin`; `start` pulsed during `busy` has no effect.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared control definitions: opcodes, ALU function codes, FSM states and IR layout.
package cpu_ctrl_pkg;

  // Instruction opcodes (IR[31:27])
  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_ROR  = 5'b00111;
  localparam logic [4:0] OP_ROL  = 5'b01000;
  localparam logic [4:0] OP_SHR  = 5'b01001;
  localparam logic [4:0] OP_SHRA = 5'b01010;
  localparam logic [4:0] OP_SHL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;

  // ALU function select codes, shared with the ALU
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;
  localparam logic [3:0] ALU_NEG  = 4'd12;
  localparam logic [3:0] ALU_NOT  = 4'd13;

  // IR field bit positions
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_DONE = 4'd8
  } state_t;

  // Instruction classes; HILO is a binary op whose result spans HI and LO
  typedef enum logic [1:0] {
    CLS_BINARY  = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_HILO    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } instr_class_t;

  // Converts a 4-bit register number to a 16-bit one-hot enable
  function automatic logic [15:0] reg_onehot(input logic [3:0] idx);
    reg_onehot = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational instruction decoder: opcode -> ALU function and class, register fields -> one-hots.
module instr_decode
  import cpu_ctrl_pkg::*;
(
  input  logic [31:0]  ir,
  output instr_class_t instr_class,
  output logic [3:0]   alu_op,
  output logic [15:0]  ra_onehot,
  output logic [15:0]  rb_onehot,
  output logic [15:0]  rc_onehot
);

  logic [4:0] opcode_s;
  logic       unused_ir_bits_s;

  assign opcode_s         = ir[OPC_MSB:OPC_LSB];
  assign unused_ir_bits_s = ^ir[RC_LSB-1:0];

  assign ra_onehot = reg_onehot(ir[RA_MSB:RA_LSB]);
  assign rb_onehot = reg_onehot(ir[RB_MSB:RB_LSB]);
  assign rc_onehot = reg_onehot(ir[RC_MSB:RC_LSB]);

  // Opcode to ALU function and instruction class
  always_comb begin
    alu_op      = ALU_ADD;
    instr_class = CLS_ILLEGAL;
    case (opcode_s)
      OP_ADD:  begin alu_op = ALU_ADD;  instr_class = CLS_BINARY; end
      OP_SUB:  begin alu_op = ALU_SUB;  instr_class = CLS_BINARY; end
      OP_AND:  begin alu_op = ALU_AND;  instr_class = CLS_BINARY; end
      OP_OR:   begin alu_op = ALU_OR;   instr_class = CLS_BINARY; end
      OP_ROR:  begin alu_op = ALU_ROR;  instr_class = CLS_BINARY; end
      OP_ROL:  begin alu_op = ALU_ROL;  instr_class = CLS_BINARY; end
      OP_SHR:  begin alu_op = ALU_SHR;  instr_class = CLS_BINARY; end
      OP_SHRA: begin alu_op = ALU_SHRA; instr_class = CLS_BINARY; end
      OP_SHL:  begin alu_op = ALU_SHL;  instr_class = CLS_BINARY; end
      OP_MUL:  begin alu_op = ALU_MUL;  instr_class = CLS_HILO;   end
      OP_DIV:  begin alu_op = ALU_DIV;  instr_class = CLS_HILO;   end
      OP_NEG:  begin alu_op = ALU_NEG;  instr_class = CLS_UNARY;  end
      OP_NOT:  begin alu_op = ALU_NOT;  instr_class = CLS_UNARY;  end
      default: begin alu_op = ALU_ADD;  instr_class = CLS_ILLEGAL; end
    endcase
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Hardwired control unit: fetch handshake plus execution of register-format ALU instructions.
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int FETCH_TIMEOUT = 15
)
(
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        PCin,
  output logic        PCout,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zlowin,
  output logic        Zhighin,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        LOin,
  output logic        HIin,
  output logic        IncPC,
  output logic        Read,
  output logic [3:0]  ALUop
);

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  state_t           state_r, next_state_s;
  logic [CNT_W-1:0] wait_cnt_r, wait_cnt_next_s;
  logic             err_r, err_next_s;

  instr_class_t     instr_class_s;
  logic [3:0]       alu_op_s;
  logic [15:0]      ra_onehot_s, rb_onehot_s, rc_onehot_s;

  instr_decode u_decode (
    .ir          (ir),
    .instr_class (instr_class_s),
    .alu_op      (alu_op_s),
    .ra_onehot   (ra_onehot_s),
    .rb_onehot   (rb_onehot_s),
    .rc_onehot   (rc_onehot_s)
  );

  assign busy = (state_r != S_IDLE);
  assign done = (state_r == S_DONE);
  assign err  = (state_r == S_DONE) && err_r;

  // State, fetch wait counter and error flag registers
  always_ff @(posedge clock) begin
    if (clear) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= '0;
      err_r      <= 1'b0;
    end else begin
      state_r    <= next_state_s;
      wait_cnt_r <= wait_cnt_next_s;
      err_r      <= err_next_s;
    end
  end

  // Next-state logic and Moore decode of all datapath strobes
  always_comb begin
    next_state_s    = state_r;
    wait_cnt_next_s = wait_cnt_r;
    err_next_s      = err_r;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    PCin     = 1'b0;
    PCout    = 1'b0;
    MARin    = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    ALUop    = 4'd0;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          next_state_s = S_T0;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
        wait_cnt_next_s = '0;
        err_next_s      = 1'b0;
        next_state_s    = S_T1;
      end
      S_T1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        // A ready in the last allowed cycle still wins over the timeout
        if (mem_ready) begin
          next_state_s = S_T2;
        end else if (wait_cnt_r == CNT_LAST) begin
          next_state_s = S_DONE;
          err_next_s   = 1'b1;
        end else begin
          wait_cnt_next_s = wait_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_T2: begin
        MDRout       = 1'b1;
        IRin         = 1'b1;
        next_state_s = S_T3;
      end
      S_T3: begin
        case (instr_class_s)
          CLS_BINARY, CLS_HILO: begin
            Rout         = rb_onehot_s;
            Yin          = 1'b1;
            next_state_s = S_T4;
          end
          CLS_UNARY: begin
            Rout         = rb_onehot_s;
            ALUop        = alu_op_s;
            Zlowin       = 1'b1;
            next_state_s = S_T5;
          end
          default: begin
            next_state_s = S_DONE;
            err_next_s   = 1'b1;
          end
        endcase
      end
      S_T4: begin
        Rout         = rc_onehot_s;
        ALUop        = alu_op_s;
        Zlowin       = 1'b1;
        Zhighin      = (instr_class_s == CLS_HILO);
        next_state_s = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (instr_class_s == CLS_HILO) begin
          LOin         = 1'b1;
          next_state_s = S_T6;
        end else begin
          Rin          = ra_onehot_s;
          next_state_s = S_DONE;
        end
      end
      S_T6: begin
        Zhighout     = 1'b1;
        HIin         = 1'b1;
        next_state_s = S_DONE;
      end
      S_DONE: begin
        next_state_s = S_IDLE;
      end
      default: begin
        next_state_s = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Scoreboard bench: a small datapath model is driven by the sequencer's strobes; each
// issued instruction pushes its expected outcome, and a monitor checks it on done.
module tb_alu_control_sequencer;

  logic        clock = 1'b0;
  logic        clear, start, mem_ready;
  logic [31:0] ir;
  logic        busy, done, err;
  logic [15:0] Rin, Rout;
  logic        PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin;
  logic        Zlowout, Zhighout, LOin, HIin, IncPC, Read;
  logic [3:0]  ALUop;

  alu_control_sequencer #(.FETCH_TIMEOUT(15)) dut (
    .clock(clock), .clear(clear), .start(start), .ir(ir), .mem_ready(mem_ready),
    .busy(busy), .done(done), .err(err), .Rin(Rin), .Rout(Rout),
    .PCin(PCin), .PCout(PCout), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .LOin(LOin), .HIin(HIin), .IncPC(IncPC), .Read(Read),
    .ALUop(ALUop)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       nm;
    int          lat;
    logic        err;
    int          reads;
    int          irins;
    int          yins;
    int          zls;
    logic [15:0] rin;
    logic [15:0] rout;
    logic [3:0]  alu;
    int          kind;   // 0: R[dst]==v0, 1: LO==v0 and HI==v1, 2: no result
    int          dst;
    logic [31:0] v0;
    logic [31:0] v1;
  } exp_t;

  exp_t sb[$];
  exp_t e_m;
  int   compared = 0;
  int   mismatched = 0;

  // Datapath model state
  logic [31:0] R [16];
  logic [31:0] PC, MAR, MDR, IR, Y, HI, LO;
  logic [63:0] Z;
  logic [31:0] bus_s, mdatain_s, mem_word;
  int          wait_n = 0;
  int          t1_cnt = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic        load_en = 1'b0;
  logic [3:0]  load_idx = 4'd0;
  logic [31:0] load_val = 32'd0;

  // Monitor accumulators
  int          a_reads, a_irins, a_yins, a_zls, a_overlap, a_stray;
  logic [15:0] a_rin, a_rout;
  logic [3:0]  a_alu;

  assign ir        = IR;
  assign mem_ready = Read && (t1_cnt == wait_n);
  assign mdatain_s = mem_ready ? mem_word : 32'hDEAD_BEEF;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] alu(input logic [3:0] op, input logic [31:0] y, input logic [31:0] b);
    logic [63:0] t;
    logic [4:0]  s;
    s = b[4:0];
    t = 64'd0;
    case (op)
      4'd0:  t = {32'd0, y + b};
      4'd1:  t = {32'd0, y - b};
      4'd2:  t = {32'd0, y & b};
      4'd3:  t = {32'd0, y | b};
      4'd4:  t = {32'd0, y >> s};
      4'd5:  t = {32'd0, 32'($signed(y) >>> s)};
      4'd6:  t = {32'd0, y << s};
      4'd8:  begin t = {y, y} >> s; t = {32'd0, t[31:0]}; end
      4'd9:  begin t = {y, y} << s; t = {32'd0, t[63:32]}; end
      4'd10: t = 64'($signed({{32{y[31]}}, y}) * $signed({{32{b[31]}}, b}));
      4'd11: if (b != 32'd0) t = {32'($signed(y) % $signed(b)), 32'($signed(y) / $signed(b))};
      4'd12: t = {32'd0, 32'd0 - b};
      4'd13: t = {32'd0, ~b};
      default: t = 64'd0;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc);
    return {op, ra, rb, rc, 15'd0};
  endfunction

  function automatic exp_t ex(string nm, int lat, logic er, int reads, int irins, int yins, int zls,
                              logic [15:0] rin, logic [15:0] rout, logic [3:0] al, int kind, int dst,
                              logic [31:0] v0, logic [31:0] v1);
    exp_t e;
    e.nm = nm; e.lat = lat; e.err = er; e.reads = reads; e.irins = irins; e.yins = yins;
    e.zls = zls; e.rin = rin; e.rout = rout; e.alu = al; e.kind = kind; e.dst = dst;
    e.v0 = v0; e.v1 = v1;
    return e;
  endfunction

  // Bus multiplexer of the datapath model
  always_comb begin
    bus_s = 32'd0;
    for (int i = 0; i < 16; i++) if (Rout[i]) bus_s = bus_s | R[i];
    if (PCout)    bus_s = bus_s | PC;
    if (MDRout)   bus_s = bus_s | MDR;
    if (Zlowout)  bus_s = bus_s | Z[31:0];
    if (Zhighout) bus_s = bus_s | Z[63:32];
  end

  // Datapath model registers
  always @(posedge clock) begin
    logic [63:0] res;
    cyc <= cyc + 1;
    if (!busy) t1_cnt <= 0; else if (Read) t1_cnt <= t1_cnt + 1;
    if (clear) begin
      PC <= 32'd0; IR <= 32'd0; MDR <= 32'd0; MAR <= 32'd0;
      Y <= 32'd0; Z <= 64'd0; HI <= 32'd0; LO <= 32'd0;
    end else begin
      if (load_en) R[load_idx] <= load_val;
      for (int i = 0; i < 16; i++) if (Rin[i]) R[i] <= bus_s;
      if (PCin)  PC  <= bus_s;
      if (MARin) MAR <= bus_s;
      if (MDRin) MDR <= Read ? mdatain_s : bus_s;
      if (IRin)  IR  <= bus_s;
      if (Yin)   Y   <= bus_s;
      if (LOin)  LO  <= bus_s;
      if (HIin)  HI  <= bus_s;
      if (Zlowin) begin
        if (IncPC) begin
          Z[31:0] <= bus_s + 32'd1;
        end else begin
          res = alu(ALUop, Y, bus_s);
          Z[31:0] <= res[31:0];
          if (Zhighin) Z[63:32] <= res[63:32];
        end
      end
    end
  end

  // Monitor: accumulate strobe activity per instruction, check against scoreboard on done
  always @(negedge clock) begin
    if (!busy) begin
      a_reads = 0; a_irins = 0; a_yins = 0; a_zls = 0; a_overlap = 0; a_stray = 0;
      a_rin = 16'd0; a_rout = 16'd0; a_alu = 4'd0;
    end else begin
      a_reads   += int'(Read);
      a_irins   += int'(IRin);
      a_yins    += int'(Yin);
      a_rin     |= Rin;
      a_rout    |= Rout;
      if (Rin != 16'd0 && Rout != 16'd0) a_overlap++;
      if (Zlowin && !IncPC) begin a_zls++; a_alu = ALUop; end
      else if (ALUop != 4'd0) a_stray++;
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e_m = sb.pop_front();
          chk({e_m.nm, ".latency"}, 64'(cyc - start_cyc + 1), 64'(e_m.lat));
          chk({e_m.nm, ".err"},     {63'd0, err}, {63'd0, e_m.err});
          chk({e_m.nm, ".reads"},   64'(a_reads), 64'(e_m.reads));
          chk({e_m.nm, ".irin"},    64'(a_irins), 64'(e_m.irins));
          chk({e_m.nm, ".yin"},     64'(a_yins), 64'(e_m.yins));
          chk({e_m.nm, ".zlowin"},  64'(a_zls), 64'(e_m.zls));
          chk({e_m.nm, ".rin"},     {48'd0, a_rin}, {48'd0, e_m.rin});
          chk({e_m.nm, ".rout"},    {48'd0, a_rout}, {48'd0, e_m.rout});
          chk({e_m.nm, ".aluop"},   {60'd0, a_alu}, {60'd0, e_m.alu});
          chk({e_m.nm, ".overlap"}, 64'(a_overlap), 64'd0);
          chk({e_m.nm, ".alu_idle"}, 64'(a_stray), 64'd0);
          if (e_m.kind == 0) begin
            chk({e_m.nm, ".result"}, {32'd0, R[e_m.dst]}, {32'd0, e_m.v0});
          end else if (e_m.kind == 1) begin
            chk({e_m.nm, ".lo"}, {32'd0, LO}, {32'd0, e_m.v0});
            chk({e_m.nm, ".hi"}, {32'd0, HI}, {32'd0, e_m.v1});
          end
        end
      end
    end
  end

  task automatic set_reg(input logic [3:0] idx, input logic [31:0] val);
    @(negedge clock);
    load_idx = idx; load_val = val; load_en = 1'b1;
    @(negedge clock);
    load_en = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 64; i++) begin
      @(negedge clock);
      if (!busy) break;
    end
    chk("idle_wait", {63'd0, busy}, 64'd0);
  endtask

  task automatic issue(input logic [31:0] instr, input int wn, input exp_t e, input int pulse_at);
    mem_word = instr;
    wait_n   = wn;
    sb.push_back(e);
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start_cyc = cyc;
    start = 1'b0;
    if (pulse_at > 0) begin
      repeat (pulse_at) @(negedge clock);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
    end
    wait_idle();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear = 1'b1; start = 1'b0; mem_word = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset.busy", {63'd0, busy}, 64'd0);
    chk("reset.done", {63'd0, done}, 64'd0);
    chk("reset.err",  {63'd0, err}, 64'd0);
    chk("reset.rin",  {48'd0, Rin}, 64'd0);
    chk("reset.rout", {48'd0, Rout}, 64'd0);
    chk("reset.aluop", {60'd0, ALUop}, 64'd0);
    chk("reset.strobes", {49'd0, PCin, PCout, MARin, MDRin, MDRout, IRin, Yin, Zlowin,
                          Zhighin, Zlowout, Zhighout, LOin, HIin, IncPC, Read}, 64'd0);
    clear = 1'b0;

    // ROL R7 <- R0 rol R4
    set_reg(4'd0, 32'h9); set_reg(4'd4, 32'h2);
    issue(32'h4382_0000, 0, ex("rol", 7, 1'b0, 1, 1, 1, 1, 16'h0080, 16'h0011, 4'd9, 0, 7, 32'h24, 32'd0), 0);

    // MUL R3 x R4
    set_reg(4'd3, 32'd6); set_reg(4'd4, 32'd7);
    issue(mk(5'b01111, 4'd0, 4'd3, 4'd4), 0, ex("mul", 8, 1'b0, 1, 1, 1, 1, 16'h0000, 16'h0018, 4'd10, 1, 0, 32'd42, 32'd0), 0);

    // NOT R2 <- ~R5
    set_reg(4'd5, 32'h0000_FFFF);
    issue(mk(5'b10010, 4'd2, 4'd5, 4'd0), 0, ex("not", 6, 1'b0, 1, 1, 0, 1, 16'h0004, 16'h0020, 4'd13, 0, 2, 32'hFFFF_0000, 32'd0), 0);

    // ADD with three wait cycles in T1
    set_reg(4'd2, 32'd100); set_reg(4'd3, 32'd23);
    issue(mk(5'b00011, 4'd1, 4'd2, 4'd3), 3, ex("add_wait", 10, 1'b0, 4, 1, 1, 1, 16'h0002, 16'h000C, 4'd0, 0, 1, 32'd123, 32'd0), 0);

    // Fetch timeout: memory never ready
    issue(mk(5'b00011, 4'd1, 4'd2, 4'd3), 1000, ex("timeout", 17, 1'b1, 15, 0, 0, 0, 16'h0, 16'h0, 4'd0, 2, 0, 32'd0, 32'd0), 0);

    // Illegal opcode
    issue(mk(5'b11111, 4'd1, 4'd2, 4'd3), 0, ex("illegal", 5, 1'b1, 1, 1, 0, 0, 16'h0, 16'h0, 4'd0, 2, 0, 32'd0, 32'd0), 0);

    // SUB with ready arriving in the last allowed T1 cycle
    set_reg(4'd7, 32'd50); set_reg(4'd8, 32'd8);
    issue(mk(5'b00100, 4'd6, 4'd7, 4'd8), 14, ex("sub_late", 21, 1'b0, 15, 1, 1, 1, 16'h0040, 16'h0180, 4'd1, 0, 6, 32'd42, 32'd0), 0);

    // DIV R9 / R10
    set_reg(4'd9, 32'd47); set_reg(4'd10, 32'd5);
    issue(mk(5'b10000, 4'd0, 4'd9, 4'd10), 0, ex("div", 8, 1'b0, 1, 1, 1, 1, 16'h0000, 16'h0600, 4'd11, 1, 0, 32'd9, 32'd2), 0);

    // NEG R11 <- -R12
    set_reg(4'd12, 32'd5);
    issue(mk(5'b10001, 4'd11, 4'd12, 4'd0), 0, ex("neg", 6, 1'b0, 1, 1, 0, 1, 16'h0800, 16'h1000, 4'd12, 0, 11, 32'hFFFF_FFFB, 32'd0), 0);

    // SHRA R13 <- R14 >>> R15
    set_reg(4'd14, 32'h8000_0010); set_reg(4'd15, 32'd4);
    issue(mk(5'b01010, 4'd13, 4'd14, 4'd15), 0, ex("shra", 7, 1'b0, 1, 1, 1, 1, 16'h2000, 16'hC000, 4'd5, 0, 13, 32'hF800_0001, 32'd0), 0);

    // AND with Ra == Rb, plus a start pulse while busy
    set_reg(4'd3, 32'h0000_F0F0); set_reg(4'd4, 32'h0000_0FF0);
    issue(mk(5'b00101, 4'd3, 4'd3, 4'd4), 0, ex("and_alias", 7, 1'b0, 1, 1, 1, 1, 16'h0008, 16'h0018, 4'd2, 0, 3, 32'h0000_00F0, 32'd0), 2);
    repeat (3) @(negedge clock);
    chk("start_ignored.busy", {63'd0, busy}, 64'd0);

    // Clear asserted during T4 of an ADD into R5
    set_reg(4'd5, 32'h5555); set_reg(4'd1, 32'd1); set_reg(4'd2, 32'd2);
    mem_word = mk(5'b00011, 4'd5, 4'd1, 4'd2);
    wait_n = 0;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1 start_cyc = cyc;
    start = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    chk("clear.in_t4", {63'd0, Zlowin && !IncPC}, 64'd1);
    clear = 1'b1;
    @(posedge clock);
    #1;
    clear = 1'b0;
    chk("clear.busy", {63'd0, busy}, 64'd0);
    chk("clear.rin",  {48'd0, Rin}, 64'd0);
    chk("clear.strobes", {45'd0, Rout, Zlowout, Zlowin, Yin}, 64'd0);
    repeat (3) @(negedge clock);
    chk("clear.no_write", {32'd0, R[5]}, 64'h5555);
    chk("clear.idle", {63'd0, busy}, 64'd0);

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
